// File: rtl/id_stage_pipelined.sv
// Instruction-decode stage with an integrated ID/EX pipeline register.
// Holds the architectural register file (write-through on read), detects
// load-use and branch-operand hazards, resolves beq/bne/j in decode and
// presents registered, bubble-safe control to EX.
module id_stage_pipelined #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc_plus4,
  input  logic [31:0]       in_instr,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc_plus4,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_dest,
  output logic              out_mem_to_reg,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_alu_src,
  output logic              out_reg_write,
  output logic [1:0]        out_alu_op,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_target
);

  localparam int unsigned IdxW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpJ     = 6'h02;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc_plus4;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    ctrl_t             ctrl;
  } idex_t;

  // Indices at or above NREGS have no backing storage.
  function automatic logic idx_ok(input logic [4:0] idx);
    return (32'(idx) < NREGS);
  endfunction

  logic [DATA_W-1:0] rf_q [NREGS];

  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              wb_hit;
  logic              is_branch;
  logic              hazard, stall, accept;
  logic [PC_W-1:0]   br_target, j_target;
  idex_t             dec;
  idex_t             idex_q, idex_d;
  logic              valid_q, valid_d;

  assign opcode    = in_instr[31:26];
  assign rs        = in_instr[25:21];
  assign rt        = in_instr[20:16];
  assign rd        = in_instr[15:11];
  assign imm       = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
  assign is_branch = (opcode == OpBeq) || (opcode == OpBne);
  assign wb_hit    = wb_en && (wb_addr != 5'd0) && idx_ok(wb_addr);

  // Register file: cleared on reset, r0 and out-of-range indices never written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_hit) begin
      rf_q[wb_addr[IdxW-1:0]] <= wb_data;
    end
  end

  // Operand read with same-cycle writeback bypass.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != 5'd0 && idx_ok(rs)) begin
      rs_data = (wb_hit && wb_addr == rs) ? wb_data : rf_q[rs[IdxW-1:0]];
    end
    if (rt != 5'd0 && idx_ok(rt)) begin
      rt_data = (wb_hit && wb_addr == rt) ? wb_data : rf_q[rt[IdxW-1:0]];
    end
  end

  // Instruction decode into the ID/EX payload format.
  always_comb begin
    dec          = '0;
    dec.pc_plus4 = in_pc_plus4;
    dec.reg1     = rs_data;
    dec.reg2     = rt_data;
    dec.imm      = imm;
    dec.rs       = rs;
    dec.rt       = rt;
    dec.dest     = rt;
    case (opcode)
      OpRtype: begin
        dec.dest           = rd;
        dec.ctrl.reg_write = 1'b1;
        dec.ctrl.alu_op    = 2'b10;
      end
      OpLw: begin
        dec.ctrl.mem_read   = 1'b1;
        dec.ctrl.mem_to_reg = 1'b1;
        dec.ctrl.alu_src    = 1'b1;
        dec.ctrl.reg_write  = 1'b1;
      end
      OpSw: begin
        dec.ctrl.mem_write = 1'b1;
        dec.ctrl.alu_src   = 1'b1;
      end
      OpAddi: begin
        dec.ctrl.alu_src   = 1'b1;
        dec.ctrl.reg_write = 1'b1;
      end
      OpBeq, OpBne: begin
        dec.ctrl.alu_op = 2'b01;
      end
      default: begin
      end
    endcase
  end

  // Hazard: the result in ID/EX is not yet usable by this instruction.
  always_comb begin
    hazard = 1'b0;
    if (in_valid && valid_q && idex_q.dest != 5'd0 &&
        (idex_q.dest == rs || idex_q.dest == rt)) begin
      hazard = idex_q.ctrl.mem_read || (is_branch && idex_q.ctrl.reg_write);
    end
  end

  assign stall    = valid_q && !out_ready;
  assign in_ready = (!stall && !hazard) || flush;
  assign accept   = in_valid && in_ready && !flush;

  // Targets wrap modulo 2^PC_W.
  assign br_target = in_pc_plus4 + PC_W'($signed({imm, 2'b00}));
  assign j_target  = PC_W'({in_instr[25:0], 2'b00});

  // Redirect only for an instruction actually consumed this cycle.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = '0;
    if (accept) begin
      if ((opcode == OpBeq && rs_data == rt_data) ||
          (opcode == OpBne && rs_data != rt_data)) begin
        redirect        = 1'b1;
        redirect_target = br_target;
      end else if (opcode == OpJ) begin
        redirect        = 1'b1;
        redirect_target = j_target;
      end
    end
  end

  // ID/EX next state: flush > stall > hazard bubble > accept > drain.
  always_comb begin
    idex_d  = idex_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d     = 1'b0;
      idex_d.ctrl = '0;
    end else if (stall) begin
      // hold everything
    end else if (hazard) begin
      valid_d     = 1'b0;
      idex_d.ctrl = '0;
    end else if (accept) begin
      idex_d  = dec;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idex_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idex_q  <= idex_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc_plus4   = idex_q.pc_plus4;
  assign out_reg1       = idex_q.reg1;
  assign out_reg2       = idex_q.reg2;
  assign out_imm        = idex_q.imm;
  assign out_rs         = idex_q.rs;
  assign out_rt         = idex_q.rt;
  assign out_dest       = idex_q.dest;
  assign out_mem_to_reg = idex_q.ctrl.mem_to_reg;
  assign out_mem_read   = idex_q.ctrl.mem_read;
  assign out_mem_write  = idex_q.ctrl.mem_write;
  assign out_alu_src    = idex_q.ctrl.alu_src;
  assign out_reg_write  = idex_q.ctrl.reg_write;
  assign out_alu_op     = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined with a scoreboard of expected ID/EX
// contents, filled when an instruction is driven and drained when it appears.
module tb_id_stage_pipelined;

  localparam int unsigned PC_W   = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc_plus4;
  logic [31:0]       in_instr;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc_plus4;
  logic [DATA_W-1:0] out_reg1, out_reg2, out_imm;
  logic [4:0]        out_rs, out_rt, out_dest;
  logic              out_mem_to_reg, out_mem_read, out_mem_write, out_alu_src, out_reg_write;
  logic [1:0]        out_alu_op;
  logic              redirect;
  logic [PC_W-1:0]   redirect_target;

  always #5 clk = ~clk;

  id_stage_pipelined #(.PC_W(PC_W), .DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_plus4(in_pc_plus4), .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc_plus4(out_pc_plus4), .out_reg1(out_reg1), .out_reg2(out_reg2),
    .out_imm(out_imm), .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest),
    .out_mem_to_reg(out_mem_to_reg), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_alu_src(out_alu_src),
    .out_reg_write(out_reg_write), .out_alu_op(out_alu_op), .redirect(redirect),
    .redirect_target(redirect_target)
  );

  // ctrl = {mem_to_reg, mem_read, mem_write, alu_src, reg_write}
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     reg1;
    logic [31:0]     reg2;
    logic [31:0]     imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic [4:0]      ctrl;
    logic [1:0]      alu;
  } exp_t;

  exp_t        sb[$];
  exp_t        dropped;
  logic [31:0] rf [32];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  // Reference read: r0 is zero, a writeback this cycle is visible at once.
  function automatic logic [31:0] rdm(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return rf[idx];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    exp_t e;
    e.pc   = pc;
    e.rs   = ins[25:21];
    e.rt   = ins[20:16];
    e.reg1 = rdm(ins[25:21]);
    e.reg2 = rdm(ins[20:16]);
    e.imm  = {{16{ins[15]}}, ins[15:0]};
    e.dest = ins[20:16];
    e.ctrl = 5'b00000;
    e.alu  = 2'b00;
    case (ins[31:26])
      6'h00: begin e.dest = ins[15:11]; e.ctrl = 5'b00001; e.alu = 2'b10; end
      6'h23: e.ctrl = 5'b11011;
      6'h2b: e.ctrl = 5'b00110;
      6'h08: e.ctrl = 5'b00011;
      6'h04, 6'h05: e.alu = 2'b01;
      default: ;
    endcase
    return e;
  endfunction

  // Advance one clock; the register-file model follows the same edge.
  task automatic cyc();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] = wb_data;
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    in_valid    = 1'b1;
    in_instr    = ins;
    in_pc_plus4 = pc;
  endtask

  task automatic push();
    sb.push_back(model(in_instr, in_pc_plus4));
  endtask

  task automatic check_out(input string tag, input bit pop);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
      return;
    end
    e = sb[0];
    chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, ".pc"},    64'(out_pc_plus4), 64'(e.pc));
    chk({tag, ".reg1"},  64'(out_reg1), 64'(e.reg1));
    chk({tag, ".reg2"},  64'(out_reg2), 64'(e.reg2));
    chk({tag, ".imm"},   64'(out_imm), 64'(e.imm));
    chk({tag, ".rs"},    64'(out_rs), 64'(e.rs));
    chk({tag, ".rt"},    64'(out_rt), 64'(e.rt));
    chk({tag, ".dest"},  64'(out_dest), 64'(e.dest));
    chk({tag, ".ctrl"},  64'({out_mem_to_reg, out_mem_read, out_mem_write, out_alu_src,
                              out_reg_write}), 64'(e.ctrl));
    chk({tag, ".alu"},   64'(out_alu_op), 64'(e.alu));
    if (pop) dropped = sb.pop_front();
  endtask

  function automatic logic [4:0] ctrl_now();
    return {out_mem_to_reg, out_mem_read, out_mem_write, out_alu_src, out_reg_write};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset = 1'b0; in_valid = 1'b0; in_pc_plus4 = '0; in_instr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_pc", 64'(out_pc_plus4), 0);
    chk("rst_reg1", 64'(out_reg1), 0);
    chk("rst_dest", 64'(out_dest), 0);
    chk("rst_ctrl", 64'({ctrl_now(), out_alu_op}), 0);
    chk("rst_redirect", 64'(redirect), 0);
    reset = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 1);

    // Back-to-back: preload r1, addi r1,r0,5 then add r2,r1,r1.
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    cyc();
    wb_en = 1'b0;
    drive(i_ins(6'h08, 5'd0, 5'd1, 16'd5), 10'h004);
    #1 chk("b2b_ready0", 64'(in_ready), 1);
    push(); cyc(); check_out("addi", 1);
    drive(r_ins(5'd2, 5'd1, 5'd1), 10'h008);
    #1 chk("b2b_ready1", 64'(in_ready), 1);
    push(); cyc(); check_out("add", 1);

    // Write-through into a same-cycle decode of rs=3.
    drive(i_ins(6'h08, 5'd3, 5'd6, 16'd1), 10'h00c);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hdeadbeef;
    #1 push(); cyc(); wb_en = 1'b0;
    check_out("wt", 1);
    chk("wt_reg1", 64'(out_reg1), 64'h deadbeef);

    // Load-use: lw r4 then add r5,r4,r0 -> one bubble.
    drive(i_ins(6'h23, 5'd0, 5'd4, 16'h0010), 10'h010);
    #1 push(); cyc(); check_out("lw", 1);
    drive(r_ins(5'd5, 5'd4, 5'd0), 10'h014);
    #1 chk("lu_ready", 64'(in_ready), 0);
    cyc();
    chk("lu_bubble_valid", 64'(out_valid), 0);
    chk("lu_bubble_ctrl", 64'({ctrl_now(), out_alu_op}), 0);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_1234;
    #1 chk("lu_retry_ready", 64'(in_ready), 1);
    push(); cyc(); wb_en = 1'b0;
    check_out("lu_add", 1);

    // Branches with r1 = r2 = 7.
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    cyc();
    wb_addr = 5'd2;
    cyc();
    wb_en = 1'b0;
    drive(i_ins(6'h04, 5'd1, 5'd2, 16'd3), 10'h010);
    #1 chk("beq_redirect", 64'(redirect), 1);
    chk("beq_target", 64'(redirect_target), 64'h01c);
    push(); cyc(); check_out("beq", 1);
    drive(i_ins(6'h05, 5'd1, 5'd2, 16'd3), 10'h010);
    #1 chk("bne_redirect", 64'(redirect), 0);
    chk("bne_target", 64'(redirect_target), 0);
    push(); cyc(); check_out("bne", 1);

    // beq right after addi r1: bubble, then resolve with the new r1 = 9.
    drive(i_ins(6'h08, 5'd0, 5'd1, 16'd9), 10'h020);
    #1 push(); cyc(); check_out("addi_r1", 1);
    drive(i_ins(6'h04, 5'd1, 5'd2, 16'd3), 10'h024);
    #1 chk("bh_ready", 64'(in_ready), 0);
    chk("bh_redirect", 64'(redirect), 0);
    cyc();
    chk("bh_bubble_valid", 64'(out_valid), 0);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd9;
    #1 chk("bh_retry_ready", 64'(in_ready), 1);
    chk("bh_retry_redirect", 64'(redirect), 0);
    push(); cyc(); wb_en = 1'b0;
    check_out("beq_late", 1);

    // bne taken backwards, beq wrapping past 2^PC_W, j truncated.
    drive(i_ins(6'h05, 5'd1, 5'd2, 16'hfffe), 10'h010);
    #1 chk("bneb_redirect", 64'(redirect), 1);
    chk("bneb_target", 64'(redirect_target), 64'h008);
    push(); cyc(); check_out("bneb", 1);
    drive(i_ins(6'h04, 5'd2, 5'd2, 16'd5), 10'h3f8);
    #1 chk("wrap_redirect", 64'(redirect), 1);
    chk("wrap_target", 64'(redirect_target), 64'h00c);
    push(); cyc(); check_out("wrap", 1);
    drive({6'h02, 26'h00001c5}, 10'h030);
    #1 chk("j_redirect", 64'(redirect), 1);
    chk("j_target", 64'(redirect_target), 64'h314);
    push(); cyc(); check_out("j", 1);

    // Write to r0 has no effect, even same-cycle.
    drive(i_ins(6'h08, 5'd0, 5'd9, 16'd1), 10'h034);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hffff_ffff;
    #1 push(); cyc(); wb_en = 1'b0;
    check_out("r0", 1);
    chk("r0_reg1", 64'(out_reg1), 0);

    // Backpressure for 3 cycles, then flush during the stall.
    drive(i_ins(6'h08, 5'd0, 5'd7, 16'h0055), 10'h038);
    #1 push(); cyc();
    out_ready = 1'b0;
    check_out("bp0", 0);
    drive(r_ins(5'd8, 5'd7, 5'd7), 10'h03c);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 64'(in_ready), 0);
      cyc();
      check_out("bp_hold", 0);
    end
    flush = 1'b1;
    #1 chk("fl_ready", 64'(in_ready), 1);
    chk("fl_redirect", 64'(redirect), 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    dropped = sb.pop_front();
    chk("fl_valid", 64'(out_valid), 0);
    chk("fl_ctrl", 64'({ctrl_now(), out_alu_op}), 0);
    out_ready = 1'b1;
    #1 chk("fl_after_ready", 64'(in_ready), 1);

    // Reset while stalled discards the held instruction and the register file.
    drive(i_ins(6'h08, 5'd3, 5'd10, 16'd0), 10'h040);
    #1 push(); cyc();
    out_ready = 1'b0; in_valid = 1'b0;
    check_out("pre_rst", 0);
    reset = 1'b0;
    cyc();
    dropped = sb.pop_front();
    chk("mrst_valid", 64'(out_valid), 0);
    chk("mrst_reg1", 64'(out_reg1), 0);
    chk("mrst_pc", 64'(out_pc_plus4), 0);
    chk("mrst_dest", 64'(out_dest), 0);
    chk("mrst_ctrl", 64'({ctrl_now(), out_alu_op}), 0);
    reset = 1'b1; out_ready = 1'b1;
    #1 chk("mrst_ready", 64'(in_ready), 1);
    drive(i_ins(6'h08, 5'd3, 5'd11, 16'd0), 10'h044);
    #1 push(); cyc();
    check_out("post_rst", 1);
    chk("rf_cleared", 64'(out_reg1), 0);
    in_valid = 1'b0;
    cyc();
    chk("sb_empty", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
